// File: rtl/led_arb_pkg.sv
// Purpose : shared types, constants and helpers for the LED arbiter.
// Latency : n/a (package only).
// Backpressure: n/a (package only).
// Contents: arb_state_t (IDLE/GRANT/ERROR), NUM_SRC, ERR_PATTERN, IDLE_PATTERN,
//           and helpers for one-hot priority pick, nibble select and priority masks.
package led_arb_pkg;

    localparam int NUM_SRC = 4;
    localparam logic [3:0] ERR_PATTERN  = 4'b1111;
    localparam logic [3:0] IDLE_PATTERN = 4'b0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        ERROR = 2'd2
    } arb_state_t;

    // One-hot of the highest set bit; bit NUM_SRC-1 has the highest priority.
    function automatic logic [NUM_SRC-1:0] pick_highest(input logic [NUM_SRC-1:0] r);
        logic [NUM_SRC-1:0] res;
        res = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (r[i]) begin
                res    = '0;
                res[i] = 1'b1;
            end
        end
        return res;
    endfunction

    // Bits strictly above the single set bit of a one-hot value.
    function automatic logic [NUM_SRC-1:0] above_mask(input logic [NUM_SRC-1:0] g);
        logic [NUM_SRC-1:0] res;
        res = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            for (int j = i + 1; j < NUM_SRC; j++) begin
                if (g[i]) begin
                    res[j] = 1'b1;
                end
            end
        end
        return res;
    endfunction

    // Nibble of the source selected by a one-hot owner (0 when no owner).
    function automatic logic [3:0] sel_nibble(input logic [4*NUM_SRC-1:0] d,
                                              input logic [NUM_SRC-1:0]   g);
        logic [3:0] res;
        res = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            res = res | (d[4*i +: 4] & {4{g[i]}});
        end
        return res;
    endfunction

endpackage

// File: rtl/led_blink_timer.sv
// Purpose : free-running blink timer; blink_phase toggles every BLINK_HALF_CYC cycles.
// Latency : phase is registered; toggles on the edge where the counter wraps.
// Backpressure: none; never stalls and never restarts except on reset.
// Ports   : clk_50m (clock), rst_n (async active-low reset), blink_phase (output).
module led_blink_timer #(
    parameter int BLINK_HALF_CYC = 12000000
) (
    input  logic clk_50m,
    input  logic rst_n,
    output logic blink_phase
);

    localparam int CNT_W = $clog2(BLINK_HALF_CYC) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_HALF_CYC - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            blink_phase <= 1'b0;
        end else if (cnt == CNT_LAST) begin
            cnt         <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/led_arbiter.sv
// Purpose : arbitrates four LED requesters by fixed priority and owns sticky error blinking.
// Latency : req/src_data -> grant/led 1 cycle; err_in rise -> err_latched/led 2 cycles.
// Backpressure: none; requesters simply wait while not granted.
// Ports   : clk_50m, rst_n, req[3:0], src_data[15:0], src_blink[3:0], err_in, err_clr
//           -> grant[3:0] (one-hot owner), led[3:0] (registered), err_latched.
// Build   : define LED_ARB_HEARTBEAT_EN to show blink_phase on led[0] while idle.
module led_arbiter
    import led_arb_pkg::*;
#(
    parameter int BLINK_HALF_CYC = 12000000,
    parameter int HOLD_CYC       = 25000000
) (
    input  logic                 clk_50m,
    input  logic                 rst_n,
    input  logic [NUM_SRC-1:0]   req,
    input  logic [4*NUM_SRC-1:0] src_data,
    input  logic [NUM_SRC-1:0]   src_blink,
    input  logic                 err_in,
    input  logic                 err_clr,
    output logic [NUM_SRC-1:0]   grant,
    output logic [3:0]           led,
    output logic                 err_latched
);

    localparam int HOLD_W = $clog2(HOLD_CYC) + 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYC - 1);

    arb_state_t         state;
    logic [HOLD_W-1:0]  hold_cnt;
    logic               err_r1;
    logic               err_r2;
    logic               blink_phase;

    led_blink_timer #(
        .BLINK_HALF_CYC (BLINK_HALF_CYC)
    ) u_blink (
        .clk_50m     (clk_50m),
        .rst_n       (rst_n),
        .blink_phase (blink_phase)
    );

    logic               err_edge;
    logic               hold_exp;
    logic [NUM_SRC-1:0] next_owner;
    logic [3:0]         owner_led;
    logic [3:0]         idle_led;
    logic [3:0]         err_led;

    assign err_edge = err_r1 & ~err_r2;
    assign hold_exp = (hold_cnt == HOLD_LAST);
    assign err_led  = blink_phase ? ERR_PATTERN : 4'b0000;

`ifdef LED_ARB_HEARTBEAT_EN
    assign idle_led = IDLE_PATTERN | {3'b000, blink_phase};
`else
    assign idle_led = IDLE_PATTERN;
`endif

    // Owner for the coming cycle. A released owner is re-arbitrated in the
    // same cycle; a live owner yields only to higher bits once expired.
    always_comb begin
        next_owner = grant;
        case (state)
            IDLE: next_owner = pick_highest(req);
            GRANT: begin
                if ((req & grant) == '0) begin
                    next_owner = pick_highest(req);
                end else if (hold_exp && ((req & above_mask(grant)) != '0)) begin
                    next_owner = pick_highest(req);
                end
            end
            default: next_owner = '0;
        endcase
    end

    always_comb begin
        owner_led = sel_nibble(src_data, next_owner);
        if (((src_blink & next_owner) != '0) && !blink_phase) begin
            owner_led = 4'b0000;
        end
    end

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            grant       <= '0;
            led         <= 4'b0000;
            err_latched <= 1'b0;
            hold_cnt    <= '0;
            // Synchroniser resets high so a level still high after reset is not
            // mistaken for a fresh rising edge.
            err_r1      <= 1'b1;
            err_r2      <= 1'b1;
        end else begin
            err_r1 <= err_in;
            err_r2 <= err_r1;
            if (err_edge) begin
                // Also covers an edge coinciding with err_clr: error wins.
                state       <= ERROR;
                grant       <= '0;
                err_latched <= 1'b1;
                led         <= err_led;
            end else begin
                case (state)
                    ERROR: begin
                        if (err_clr) begin
                            state       <= IDLE;
                            err_latched <= 1'b0;
                            led         <= idle_led;
                        end else begin
                            led <= err_led;
                        end
                    end
                    default: begin
                        if (next_owner == '0) begin
                            state <= IDLE;
                            grant <= '0;
                            led   <= idle_led;
                        end else begin
                            state <= GRANT;
                            grant <= next_owner;
                            led   <= owner_led;
                            if (next_owner != grant) begin
                                hold_cnt <= '0;
                            end else if (!hold_exp) begin
                                hold_cnt <= hold_cnt + HOLD_W'(1);
                            end
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_led_arbiter.sv
// Purpose : self-checking bench for led_arbiter (BLINK_HALF_CYC=8, HOLD_CYC=16).
// Latency : expected values queued before each edge, compared 1 time unit after it.
// Backpressure: n/a.
module tb_led_arbiter;
    import led_arb_pkg::*;

    logic        clk_50m = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [15:0] src_data;
    logic [3:0]  src_blink;
    logic        err_in;
    logic        err_clr;
    logic [3:0]  grant;
    logic [3:0]  led;
    logic        err_latched;

    int checks = 0;
    int errors = 0;
    int edges;

    led_arbiter #(
        .BLINK_HALF_CYC (8),
        .HOLD_CYC       (16)
    ) dut (
        .clk_50m     (clk_50m),
        .rst_n       (rst_n),
        .req         (req),
        .src_data    (src_data),
        .src_blink   (src_blink),
        .err_in      (err_in),
        .err_clr     (err_clr),
        .grant       (grant),
        .led         (led),
        .err_latched (err_latched)
    );

    always #10 clk_50m = ~clk_50m;

    // Edges since reset release; the blink phase seen before edge k is (k-1)/8 mod 2.
    always @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) edges <= 0;
        else        edges <= edges + 1;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    typedef struct {
        string      name;
        logic [3:0] g;
        logic [3:0] l;
        logic       e;
    } exp_t;

    exp_t sb[$];

    typedef struct {
        logic [3:0]  req;
        logic [15:0] data;
        logic [3:0]  g;
        logic [3:0]  l;
        bit          idle;
    } vec_t;

    vec_t vecs[10];

    // Blink phase that the DUT samples on the coming edge.
    function automatic logic ph();
        return 1'((edges / 8) % 2);
    endfunction

    function automatic logic [3:0] idle_exp();
`ifdef LED_ARB_HEARTBEAT_EN
        return {3'b000, ph()};
`else
        return 4'b0000;
`endif
    endfunction

    function automatic logic [3:0] err_exp();
        return ph() ? 4'hF : 4'h0;
    endfunction

    task automatic compare_head();
        exp_t x;
        x = sb.pop_front();
        checks++;
        if (grant !== x.g || led !== x.l || err_latched !== x.e) begin
            errors++;
            $display("FAIL %s: got grant=%b led=%h err=%b, expected grant=%b led=%h err=%b",
                     x.name, grant, led, err_latched, x.g, x.l, x.e);
        end
    endtask

    task automatic push_exp(input string nm, input logic [3:0] g, input logic [3:0] l,
                            input logic e);
        exp_t x;
        x.name = nm; x.g = g; x.l = l; x.e = e;
        sb.push_back(x);
    endtask

    // Queue the expectation for the next edge, advance one clock, compare.
    task automatic chk(input string nm, input logic [3:0] g, input logic [3:0] l,
                       input logic e);
        push_exp(nm, g, l, e);
        @(posedge clk_50m);
        #1;
        compare_head();
    endtask

    initial begin
        rst_n = 1'b0; req = '0; src_data = '0; src_blink = '0;
        err_in = 1'b0; err_clr = 1'b0;

        vecs[0] = '{4'b0001, 16'h000A, 4'b0001, 4'hA, 1'b0};
        vecs[1] = '{4'b0001, 16'h0003, 4'b0001, 4'h3, 1'b0};
        vecs[2] = '{4'b0011, 16'h0053, 4'b0001, 4'h3, 1'b0};
        vecs[3] = '{4'b0010, 16'h0053, 4'b0010, 4'h5, 1'b0};
        vecs[4] = '{4'b0110, 16'h0753, 4'b0010, 4'h5, 1'b0};
        vecs[5] = '{4'b0100, 16'h0753, 4'b0100, 4'h7, 1'b0};
        vecs[6] = '{4'b0000, 16'h0753, 4'b0000, 4'h0, 1'b1};
        vecs[7] = '{4'b1001, 16'h9753, 4'b1000, 4'h9, 1'b0};
        vecs[8] = '{4'b1000, 16'hC753, 4'b1000, 4'hC, 1'b0};
        vecs[9] = '{4'b0000, 16'hC753, 4'b0000, 4'h0, 1'b1};

        // Reset state
        #5;
        push_exp("reset", 4'b0000, 4'h0, 1'b0);
        compare_head();
        @(posedge clk_50m); #1;
        push_exp("reset_clocked", 4'b0000, 4'h0, 1'b0);
        compare_head();
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) chk("idle_after_reset", 4'b0000, idle_exp(), 1'b0);

        // Table-driven basic arbitration
        for (int i = 0; i < 10; i++) begin
            req = vecs[i].req;
            src_data = vecs[i].data;
            chk($sformatf("vec%0d", i), vecs[i].g, vecs[i].idle ? idle_exp() : vecs[i].l, 1'b0);
        end

        // Hold protection then preemption by source 3
        src_data = 16'h500A;
        req = 4'b0001;
        chk("pre_grant", 4'b0001, 4'hA, 1'b0);
        for (int k = 1; k <= 15; k++) begin
            if (k == 5) req = 4'b1001;
            chk($sformatf("hold_k%0d", k), 4'b0001, 4'hA, 1'b0);
        end
        chk("preempt", 4'b1000, 4'h5, 1'b0);
        req = 4'b1011;
        src_data = 16'h502A;
        for (int k = 0; k < 20; k++) chk("no_low_preempt", 4'b1000, 4'h5, 1'b0);
        req = 4'b0000;
        chk("pre_release", 4'b0000, idle_exp(), 1'b0);

        // Blinking owner, released before expiry
        src_blink = 4'b0010;
        src_data = 16'h00F0;
        req = 4'b0010;
        for (int k = 0; k < 14; k++) chk("blink", 4'b0010, ph() ? 4'hF : 4'h0, 1'b0);
        req = 4'b0000;
        chk("blink_release", 4'b0000, idle_exp(), 1'b0);
        src_blink = 4'b0000;

        // Error entry while source 2 owns, then clear
        src_data = 16'h0600;
        req = 4'b0100;
        chk("err_pre_grant", 4'b0100, 4'h6, 1'b0);
        err_in = 1'b1;
        chk("err_sync", 4'b0100, 4'h6, 1'b0);
        chk("err_enter", 4'b0000, err_exp(), 1'b1);
        for (int k = 0; k < 16; k++) begin
            req = 4'($urandom_range(0, 15));
            chk("err_ignores_req", 4'b0000, err_exp(), 1'b1);
        end
        req = 4'b0100;
        err_clr = 1'b1;
        chk("err_clear", 4'b0000, idle_exp(), 1'b0);
        err_clr = 1'b0;
        chk("regrant", 4'b0100, 4'h6, 1'b0);

        // Error edge coinciding with err_clr
        err_in = 1'b0;
        for (int k = 0; k < 3; k++) chk("err_fall", 4'b0100, 4'h6, 1'b0);
        err_in = 1'b1;
        chk("err2_sync", 4'b0100, 4'h6, 1'b0);
        chk("err2_enter", 4'b0000, err_exp(), 1'b1);
        err_in = 1'b0;
        for (int k = 0; k < 3; k++) chk("err2_hold", 4'b0000, err_exp(), 1'b1);
        err_in = 1'b1;
        chk("err3_sync", 4'b0000, err_exp(), 1'b1);
        err_clr = 1'b1;
        chk("clr_coincide", 4'b0000, err_exp(), 1'b1);
        err_clr = 1'b0;
        chk("stay_error", 4'b0000, err_exp(), 1'b1);

        // Asynchronous reset while in error, err_in left high
        rst_n = 1'b0;
        #1;
        push_exp("async_reset", 4'b0000, 4'h0, 1'b0);
        compare_head();
        req = 4'b0000;
        src_data = 16'h000A;
        @(posedge clk_50m); #1;
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) chk("post_rst_idle", 4'b0000, idle_exp(), 1'b0);
        req = 4'b0001;
        for (int k = 0; k < 5; k++) chk("post_rst_grant", 4'b0001, 4'hA, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/led_arbiter.md
# led_arbiter

Arbitrates the four on-board LEDs among four status requesters (e.g. SDRAM test progress, cycle counter, user pattern, debug) and owns error indication for the whole design. A sticky error mode overrides all requesters and blinks the LEDs until software or a button clears it. Sits between the test/status logic and the `led` pins, in the `clk_50m` domain, and replaces per-source LED drivers.

## Interface
- `BLINK_HALF_CYC`, default 12000000: clock cycles per blink half-period.
- `HOLD_CYC`, default 25000000: minimum clock cycles a grant is protected from preemption; must be ≥1.
- `clk_50m` input 1: system clock; the block's only clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `req` input 4: per-source display request; bit 3 has the highest priority.
- `src_data` input 16: nibble i (`[4i+3:4i]`) is source i's LED pattern.
- `src_blink` input 4: when bit i is 1, source i's pattern blinks; when 0, it is steady.
- `err_in` input 1: error flag, level, may be asynchronous; its rising edge enters error mode.
- `err_clr` input 1: single-cycle pulse that clears error mode.
- `grant` output 4: one-hot current owner; 0 when no source owns the LEDs.
- `led` output 4: LED drive, registered.
- `err_latched` output 1: 1 while in error mode.

## Operation
- States: IDLE, GRANT, ERROR. All outputs reset to 0 and the state resets to IDLE.
- `err_in` passes through two flops, r1 then r2. The error edge is `r1 & ~r2`.
- An error edge in any state moves to ERROR.
- ERROR:
  - `grant`=0 and `err_latched`=1.
  - `led` shows 4'b1111 when blink_phase=1 and 4'b0000 otherwise.
  - `req` is ignored.
  - `err_clr` with no simultaneous error edge moves to IDLE. If the error edge and `err_clr` coincide, the block stays in ERROR.
- IDLE:
  - `led`=0 and `grant`=0.
  - Any `req` bit moves to GRANT for the highest set bit.
- GRANT, owner o:
  - `led` = nibble o. If `src_blink[o]`=1, `led` shows nibble o when blink_phase=1 and 0 otherwise.
  - The hold counter clears on every new grant and saturates at HOLD_CYC−1. The grant is "expired" when the counter equals HOLD_CYC−1.
  - If `req[o]` drops, the owner is released immediately, even before expiry. The same cycle re-arbitrates among the remaining bits; with none set, the state goes to IDLE.
  - If the grant is expired and a higher-priority bit is set, the grant moves to the highest set bit.
  - Lower-priority requests never preempt.
- Blink timer:
  - Free-running counter from 0 to BLINK_HALF_CYC−1.
  - blink_phase toggles on each wrap; it resets to 0 and the counter resets to 0.
  - It never restarts on a grant change.
- Counter widths are `$clog2` of their terminal count plus one guard bit; no wrap other than the defined terminal wraps.

## Timing
- `req`/`src_data` to `grant`/`led`: 1 cycle. The state, `grant` and `led` update on the same edge.
- Change of an owner's `src_data` while it is granted: `led` follows 1 cycle later.
- `err_in` rising to `err_latched`=1 and `led`: 2 cycles. `led` takes the pattern set by the current blink_phase.
- `err_clr` to IDLE: 1 cycle. A new grant is possible on the following edge.
- Reset asserted mid-operation: all outputs go to 0 asynchronously. The error latch is lost; `err_in` still high after reset does not re-trigger error mode without a new edge.

## Configuration
- `LED_ARB_HEARTBEAT_EN` defined: in IDLE, `led[0]` = blink_phase and the other bits are 0, giving an alive indication.
- Not defined: IDLE drives `led`=4'b0000.
- ERROR and GRANT behaviour are identical in both builds.

## Structure
- Package `led_arb_pkg` holds:
  - the state enum (IDLE, GRANT, ERROR);
  - the localparam NUM_SRC=4;
  - ERR_PATTERN=4'b1111;
  - IDLE_PATTERN=4'b0000.
- Sub-module `led_blink_timer` (parameter BLINK_HALF_CYC; ports `clk_50m`, `rst_n`, `blink_phase`) holds the free-running blink timer.
- The arbitration FSM, hold counter and error synchroniser stay in `led_arbiter`.

## Test plan
All scenarios use BLINK_HALF_CYC=8 and HOLD_CYC=16.
- Reset → `led`=0, `grant`=0, `err_latched`=0; deassert reset with `req`=0 → outputs stay 0 (1 on `led[0]` at the blink rate when `LED_ARB_HEARTBEAT_EN` is defined).
- `req`=4'b0001, nibble0=4'hA, steady → 1 cycle later `grant`=0001, `led`=4'hA; nibble0 changes to 4'h3 → `led`=4'h3 next cycle.
- Source 0 granted; assert `req[3]` (nibble3=4'h5) 5 cycles into the grant → `grant` stays 0001 until the hold expires (cycle 16 of the grant), then `grant`=1000 and `led`=4'h5 one cycle later; asserting `req[1]` while source 3 is owner has no effect.
- Source 1 granted, `src_blink[1]`=1, nibble1=4'hF → `led` alternates 4'hF and 4'h0 every 8 cycles, in phase with the timer; dropping `req[1]` before the hold expires → IDLE next cycle.
- `err_in` rises while source 2 is granted → 2 cycles later `err_latched`=1, `grant`=0, `led` blinks 1111/0000; toggling `req` has no effect; pulse `err_clr` → IDLE next cycle, then a grant follows.
- Error edge and `err_clr` on the same cycle → stays in ERROR; assert `rst_n` low while in ERROR → all outputs 0 immediately, with `err_in` still high.
